stream_mux_arb: RTL

Parametrised N-channel, n-bit stream multiplexer with built-in arbitration and a registered output. It generalises the 4:1 combinational n-bit mux: channel selection is produced internally by a round-robin or fixed-priority arbiter rather than a select input, and every channel and the output carry a valid/ready handshake. It sits between multiple producers and a single downstream consumer. It sustains one word per cycle with one cycle of latency.

---
 rtl/stream_mux_arb.sv | 98 +++++++++
 1 files changed

// File: rtl/stream_mux_arb.sv
// rtl/stream_mux_arb.sv - N-channel stream mux with round-robin/fixed-priority arbiter and registered output
module stream_mux_arb #(
    parameter int n    = 4,
    parameter int CH   = 4,
    parameter int MODE = 0,
    localparam int SW  = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [CH*n-1:0]   D,
    input  logic [CH-1:0]     V,
    output logic [CH-1:0]     R,
    output logic [n-1:0]      Y,
    output logic              YV,
    input  logic              YR,
    output logic [SW-1:0]     S
);

    logic [n-1:0]  y_q, y_d;
    logic [SW-1:0] s_q, s_d;
    logic          yv_q, yv_d;
    logic [SW-1:0] p_q, p_d;

    logic          ld;
    logic          found;
    logic          grant;
    logic [SW-1:0] g;
    logic [SW-1:0] cand;
    logic [n-1:0]  sel_data;

    assign ld    = ~yv_q | YR;
    assign grant = found & ld & ~RST;

    // Round-robin starts one past the last winner; fixed priority always starts at 0.
    always_comb begin
        found = 1'b0;
        g     = '0;
        cand  = '0;
        for (int i = 0; i < CH; i++) begin
            if (MODE == 0) begin
                cand = SW'((int'(p_q) + i + 1) % CH);
            end else begin
                cand = SW'(i);
            end
            if (!found && V[cand]) begin
                found = 1'b1;
                g     = cand;
            end
        end
    end

    always_comb begin
        R        = '0;
        sel_data = '0;
        for (int k = 0; k < CH; k++) begin
            if (SW'(k) == g) begin
                sel_data = D[k*n +: n];
                R[k]     = grant;
            end
        end
    end

    always_comb begin
        y_d  = y_q;
        s_d  = s_q;
        yv_d = yv_q;
        p_d  = p_q;
        if (grant) begin
            y_d  = sel_data;
            s_d  = g;
            yv_d = 1'b1;
            if (MODE == 0) begin
                p_d = g;
            end
        end else if (ld) begin
            yv_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            y_q  <= '0;
            s_q  <= '0;
            yv_q <= 1'b0;
            p_q  <= SW'(CH - 1);
        end else begin
            y_q  <= y_d;
            s_q  <= s_d;
            yv_q <= yv_d;
            p_q  <= p_d;
        end
    end

    assign Y  = y_q;
    assign YV = yv_q;
    assign S  = s_q;

endmodule
